// File: rtl/txn_risk_scorer.sv
// txn_risk_scorer: tracks per-wallet transaction statistics and, on request,
// computes a 0..100 risk confidence score for one wallet. Four ratios are
// computed one after another on a single shared restoring divider.
module txn_risk_scorer #(
    parameter int NUM_WALLETS = 4,
    parameter int VALUE_W     = 20,
    parameter int TS_W        = 31,
    parameter int CNT_W       = 16,
    parameter int DIV_W       = 40,
    localparam int WID        = (NUM_WALLETS > 1) ? $clog2(NUM_WALLETS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               txn_valid,
    input  logic [WID-1:0]     txn_wallet,
    input  logic               txn_in,
    input  logic [1:0]         txn_method,
    input  logic [VALUE_W-1:0] txn_value,
    input  logic [TS_W-1:0]    txn_time,
    input  logic               clr_valid,
    input  logic [WID-1:0]     clr_wallet,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WID-1:0]     req_wallet,
    output logic               score_valid,
    output logic [WID-1:0]     score_wallet,
    output logic [6:0]         score,
    output logic [6:0]         m_score,
    output logic [6:0]         i_score,
    output logic [6:0]         v_score,
    output logic [6:0]         p_score
);

    localparam int BCW = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] HUNDRED = DIV_W'(100);

    typedef enum logic [2:0] {IDLE, LOAD, DIV_M, DIV_I, DIV_V, DIV_P, SUM} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] in_cnt;
        logic [CNT_W-1:0] oth_cnt;
        logic             priv;
        logic [DIV_W-1:0] vsum;
        logic [TS_W-1:0]  t_first;
        logic [TS_W-1:0]  t_last;
    } wallet_t;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [DIV_W-1:0] sat_add(input logic [DIV_W-1:0] a,
                                                 input logic [VALUE_W-1:0] b);
        logic [DIV_W:0] s;
        s = {1'b0, a} + (DIV_W+1)'(b);
        return s[DIV_W] ? '1 : s[DIV_W-1:0];
    endfunction

    // A clear on the same wallet is applied before the transaction.
    function automatic wallet_t next_wallet(input wallet_t cur, input logic clr,
                                            input logic hit);
        wallet_t n;
        n = clr ? '0 : cur;
        if (hit) begin
            if (n.cnt == '0) n.t_first = txn_time;
            n.t_last = txn_time;
            n.cnt    = sat_inc(n.cnt);
            if (txn_in) n.in_cnt = sat_inc(n.in_cnt);
            case (txn_method)
                2'b00, 2'b01: n.priv    = 1'b1;
                2'b10:        n.oth_cnt = sat_inc(n.oth_cnt);
                default:      ;
            endcase
            n.vsum = sat_add(n.vsum, txn_value);
        end
        return n;
    endfunction

    function automatic logic [6:0] m_pts(input logic priv, input logic [DIV_W-1:0] pct);
        if (priv || pct >= DIV_W'(15)) return 7'd15;
        if (pct >= DIV_W'(10))         return 7'd10;
        if (pct >= DIV_W'(5))          return 7'd5;
        return 7'd0;
    endfunction

    function automatic logic [6:0] i_pts(input logic [DIV_W-1:0] pct);
        if (pct >= DIV_W'(95) || pct <= DIV_W'(5))  return 7'd35;
        if (pct >= DIV_W'(90) || pct <= DIV_W'(10)) return 7'd30;
        if (pct >= DIV_W'(85) || pct <= DIV_W'(15)) return 7'd25;
        if (pct >= DIV_W'(80) || pct <= DIV_W'(20)) return 7'd20;
        if (pct >= DIV_W'(75) || pct <= DIV_W'(25)) return 7'd15;
        if (pct >= DIV_W'(70) || pct <= DIV_W'(30)) return 7'd10;
        return 7'd0;
    endfunction

    function automatic logic [6:0] v_pts(input logic [DIV_W-1:0] avg);
        if (avg >= DIV_W'(400000)) return 7'd20;
        if (avg >= DIV_W'(200000)) return 7'd17;
        if (avg >= DIV_W'(100000)) return 7'd14;
        if (avg >= DIV_W'(50000))  return 7'd10;
        if (avg >= DIV_W'(10000))  return 7'd7;
        return 7'd0;
    endfunction

    function automatic logic [6:0] p_pts(input logic [DIV_W-1:0] per);
        if (per >= DIV_W'(3600)) return 7'd30;
        if (per >= DIV_W'(1800)) return 7'd25;
        if (per >= DIV_W'(720))  return 7'd20;
        if (per >= DIV_W'(60))   return 7'd15;
        if (per >= DIV_W'(1))    return 7'd5;
        return 7'd0;
    endfunction

    // ---------------------------------------------------------------------
    // Per-wallet statistics
    // ---------------------------------------------------------------------
    wallet_t wal    [NUM_WALLETS];
    wallet_t wal_nx [NUM_WALLETS];

    // Next statistics for every wallet from this cycle's clear and transaction.
    always_comb begin
        for (int w = 0; w < NUM_WALLETS; w++) begin
            wal_nx[w] = next_wallet(wal[w],
                                    clr_valid && (clr_wallet == WID'(w)),
                                    txn_valid && (txn_wallet == WID'(w)));
        end
    end

    // Wallet statistics register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the wallet table is a handful of flops, so it is reset
            // directly; a RAM-based table would need a clear sweep instead.
            for (int w = 0; w < NUM_WALLETS; w++) wal[w] <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            wal <= wal_nx;
        end
    end

    // ---------------------------------------------------------------------
    // Request snapshot selection (pre-update state, zero if out of range)
    // ---------------------------------------------------------------------
    wallet_t         sel;
    logic [TS_W-1:0] sel_per;

    // Pick the requested wallet's current statistics.
    always_comb begin
        // NOTE: default assignment first so no path leaves it unassigned (no latch).
        sel = '0;
        if (int'(req_wallet) < NUM_WALLETS) sel = wal[req_wallet];
    end

    // Unsigned modular span; handles timestamp wrap.
    assign sel_per = sel.t_last - sel.t_first;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    state_t          state, state_nx;
    logic [BCW-1:0]  bit_cnt;
    logic            bit_last;

    assign req_ready = (state == IDLE);
    assign bit_last  = (bit_cnt == BCW'(DIV_W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state sequencing; SUM holds for the output pulse cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = LOAD;
            LOAD:    state_nx = DIV_M;
            DIV_M:   if (bit_last) state_nx = DIV_I;
            DIV_I:   if (bit_last) state_nx = DIV_V;
            DIV_V:   if (bit_last) state_nx = DIV_P;
            DIV_P:   if (bit_last) state_nx = SUM;
            SUM:     if (score_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Shared restoring divider and snapshot
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] dvd_m, dvd_i, dvd_v, dvd_p, dvs;
    logic [DIV_W-1:0] rem, quo, rem_nx, quo_nx;
    logic [DIV_W:0]   rem_sh;
    logic             sub_ok;
    logic [DIV_W-1:0] q_m, q_i, q_v, q_p;
    logic             snap_zero, snap_priv;
    logic [WID-1:0]   snap_wallet;

    // One quotient bit per cycle: shift in the next dividend bit, try subtract.
    always_comb begin
        rem_sh = {rem, quo[DIV_W-1]};
        sub_ok = (rem_sh >= {1'b0, dvs});
        rem_nx = sub_ok ? DIV_W'(rem_sh - {1'b0, dvs}) : rem_sh[DIV_W-1:0];
        quo_nx = {quo[DIV_W-2:0], sub_ok};
    end

    // Snapshot on acceptance, then run the four divides back to back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_m <= '0; dvd_i <= '0; dvd_v <= '0; dvd_p <= '0; dvs <= '0;
            rem <= '0; quo <= '0; bit_cnt <= '0;
            q_m <= '0; q_i <= '0; q_v <= '0; q_p <= '0;
            snap_zero <= 1'b0; snap_priv <= 1'b0; snap_wallet <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    dvd_m       <= HUNDRED * DIV_W'(sel.oth_cnt);
                    dvd_i       <= HUNDRED * DIV_W'(sel.in_cnt);
                    dvd_v       <= sel.vsum;
                    dvd_p       <= DIV_W'(sel_per);
                    dvs         <= DIV_W'(sel.cnt);
                    snap_zero   <= (sel.cnt == '0);
                    snap_priv   <= sel.priv;
                    snap_wallet <= req_wallet;
                end
                LOAD: begin
                    rem     <= '0;
                    quo     <= dvd_m;
                    bit_cnt <= '0;
                end
                DIV_M, DIV_I, DIV_V, DIV_P: begin
                    if (!bit_last) begin
                        rem     <= rem_nx;
                        quo     <= quo_nx;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        rem     <= '0;
                        bit_cnt <= '0;
                        case (state)
                            DIV_M:   begin q_m <= quo_nx; quo <= dvd_i; end
                            DIV_I:   begin q_i <= quo_nx; quo <= dvd_v; end
                            DIV_V:   begin q_v <= quo_nx; quo <= dvd_p; end
                            default: begin q_p <= quo_nx; end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Component scoring and result outputs
    // ---------------------------------------------------------------------
    logic [6:0] m_c, i_c, v_c, p_c;

    // Empty snapshot forces every component to zero.
    always_comb begin
        m_c = 7'd0;
        i_c = 7'd0;
        v_c = 7'd0;
        p_c = 7'd0;
        if (!snap_zero) begin
            m_c = m_pts(snap_priv, q_m);
            i_c = i_pts(q_i);
            v_c = v_pts(q_v);
            p_c = p_pts(q_p);
        end
    end

    // Register the result on SUM entry and pulse score_valid for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_valid  <= 1'b0;
            score_wallet <= '0;
            score        <= '0;
            m_score      <= '0;
            i_score      <= '0;
            v_score      <= '0;
            p_score      <= '0;
        end else if (state == SUM && !score_valid) begin
            score_valid  <= 1'b1;
            score_wallet <= snap_wallet;
            m_score      <= m_c;
            i_score      <= i_c;
            v_score      <= v_c;
            p_score      <= p_c;
            score        <= m_c + i_c + v_c + p_c;
        end else begin
            score_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_txn_risk_scorer.sv
// Testbench for txn_risk_scorer: table of wallet scenarios plus hand-written
// sequences for clear/txn collisions, held requests, reset abort, saturation.
module tb_txn_risk_scorer;

    localparam int NW      = 4;
    localparam int WID     = 2;
    localparam int VALUE_W = 20;
    localparam int TS_W    = 31;
    localparam int CNT_W   = 16;
    localparam int DIV_W   = 40;
    localparam int LAT     = 3 + 4 * DIV_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               txn_valid;
    logic [WID-1:0]     txn_wallet;
    logic               txn_in;
    logic [1:0]         txn_method;
    logic [VALUE_W-1:0] txn_value;
    logic [TS_W-1:0]    txn_time;
    logic               clr_valid;
    logic [WID-1:0]     clr_wallet;
    logic               req_valid;
    logic               req_ready;
    logic [WID-1:0]     req_wallet;
    logic               score_valid;
    logic [WID-1:0]     score_wallet;
    logic [6:0]         score, m_score, i_score, v_score, p_score;

    txn_risk_scorer #(
        .NUM_WALLETS(NW), .VALUE_W(VALUE_W), .TS_W(TS_W), .CNT_W(CNT_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .txn_valid(txn_valid), .txn_wallet(txn_wallet), .txn_in(txn_in),
        .txn_method(txn_method), .txn_value(txn_value), .txn_time(txn_time),
        .clr_valid(clr_valid), .clr_wallet(clr_wallet),
        .req_valid(req_valid), .req_ready(req_ready), .req_wallet(req_wallet),
        .score_valid(score_valid), .score_wallet(score_wallet), .score(score),
        .m_score(m_score), .i_score(i_score), .v_score(v_score), .p_score(p_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WID-1:0] wallet;
        logic [6:0]     m, i, v, p, s;
        int             acc;
    } exp_t;

    typedef struct {
        int          w, n, n_in;
        logic [1:0]  m0, mr;
        int          val;
        logic [30:0] t0;
        int          step;
        int          em, ei, ev, ep;
    } vec_t;

    exp_t sb[$];
    exp_t next_exp;
    vec_t vecs[10];
    int   checks = 0, errors = 0;
    int   cyc = 0, n_acc = 0, n_pulse = 0;
    bit   acc_prev = 0, pulse_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input int w, input int m, input int i, input int v, input int p);
        exp_t e;
        e.wallet = WID'(w);
        e.m = 7'(m); e.i = 7'(i); e.v = 7'(v); e.p = 7'(p);
        e.s = 7'(m + i + v + p);
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (acc_prev) begin
            check("req_ready_drop", req_ready, 1'b0);
            acc_prev = 0;
        end
        if (pulse_prev) begin
            check("req_ready_return", req_ready, 1'b1);
            pulse_prev = 0;
        end
        if (score_valid) begin
            n_pulse++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_score_valid: got pulse, expected none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.acc, LAT);
                check("score_wallet", score_wallet, e.wallet);
                check("m_score", m_score, e.m);
                check("i_score", i_score, e.i);
                check("v_score", v_score, e.v);
                check("p_score", p_score, e.p);
                check("score", score, e.s);
                check("req_ready_in_pulse", req_ready, 1'b0);
                pulse_prev = 1;
            end
        end
        if (rst_n && req_valid && req_ready) begin
            e = next_exp;
            e.wallet = req_wallet;
            e.acc = cyc;
            sb.push_back(e);
            n_acc++;
            acc_prev = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() != 0 || !req_ready) && g < 600) begin
            tick();
            g++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic request(input int w, input exp_t e);
        int g = 0;
        while (!req_ready && g < 600) begin
            tick();
            g++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        next_exp   = e;
        req_wallet = WID'(w);
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        wait_drain();
    endtask

    task automatic do_clear(input int w);
        clr_valid  = 1'b1;
        clr_wallet = WID'(w);
        tick();
        clr_valid  = 1'b0;
    endtask

    task automatic set_txn(input int w, input logic in, input logic [1:0] meth,
                           input int val, input logic [30:0] t);
        txn_valid  = 1'b1;
        txn_wallet = WID'(w);
        txn_in     = in;
        txn_method = meth;
        txn_value  = VALUE_W'(val);
        txn_time   = t;
    endtask

    task automatic apply_vec(input vec_t v);
        do_clear(v.w);
        for (int k = 0; k < v.n; k++) begin
            set_txn(v.w, k < v.n_in, (k == 0) ? v.m0 : v.mr, v.val, v.t0 + 31'(k * v.step));
            tick();
        end
        txn_valid = 1'b0;
        request(v.w, mk_exp(v.w, v.em, v.ei, v.ev, v.ep));
    endtask

    initial begin
        int a0, p0;
        rst_n = 1'b0; txn_valid = 0; txn_wallet = 0; txn_in = 0; txn_method = 0;
        txn_value = 0; txn_time = 0; clr_valid = 0; clr_wallet = 0;
        req_valid = 0; req_wallet = 0;
        next_exp = mk_exp(0, 0, 0, 0, 0);

        //          w  n   in  m0     mr     value   t0            step  m   i   v   p
        vecs[0] = '{1, 20, 20, 2'b10, 2'b10, 50000,  31'd0,        100,  15, 35, 10, 15};
        vecs[1] = '{2, 10, 5,  2'b01, 2'b11, 500000, 31'd1000,     0,    15, 0,  20, 0};
        vecs[2] = '{0, 3,  0,  2'b11, 2'b11, 9999,   31'd5,        3600, 0,  35, 0,  25};
        vecs[3] = '{3, 7,  6,  2'b10, 2'b11, 100000, 31'd0,        4200, 10, 25, 14, 30};
        vecs[4] = '{1, 20, 2,  2'b10, 2'b11, 200000, 31'd0,        240,  5,  30, 17, 15};
        vecs[5] = '{2, 4,  3,  2'b10, 2'b10, 10000,  31'd0,        1,    15, 15, 7,  0};
        vecs[6] = '{0, 5,  1,  2'b10, 2'b11, 400000, 31'd0,        1200, 15, 20, 20, 20};
        vecs[7] = '{3, 1,  1,  2'b11, 2'b11, 1,      31'd42,       0,    0,  35, 0,  0};
        vecs[8] = '{1, 2,  1,  2'b11, 2'b11, 50000,  31'd0,        2,    0,  0,  10, 5};
        vecs[9] = '{2, 2,  0,  2'b11, 2'b11, 0,      31'h7FFFFF9C, 600,  0,  35, 0,  15};

        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_score_valid", score_valid, 1'b0);
        check("rst_score", score, 7'd0);
        check("rst_score_wallet", score_wallet, 2'd0);
        check("rst_m_score", m_score, 7'd0);
        check("rst_p_score", p_score, 7'd0);
        rst_n = 1'b1;
        tick();

        // Empty wallet after reset scores zero with fixed latency.
        request(0, mk_exp(0, 0, 0, 0, 0));

        foreach (vecs[k]) apply_vec(vecs[k]);

        // Request concurrent with the first txn to a fresh wallet sees the empty snapshot.
        do_clear(3);
        set_txn(3, 1'b1, 2'b10, 400000, 31'd5);
        next_exp   = mk_exp(3, 0, 0, 0, 0);
        req_wallet = 2'd3;
        req_valid  = 1'b1;
        tick();
        txn_valid = 1'b0;
        req_valid = 1'b0;
        wait_drain();

        // Clear and txn in the same cycle: clear first, leaving cnt=1, period 0.
        clr_valid  = 1'b1;
        clr_wallet = 2'd3;
        set_txn(3, 1'b1, 2'b10, 400000, 31'd77);
        tick();
        clr_valid = 1'b0;
        txn_valid = 1'b0;
        request(3, mk_exp(3, 15, 35, 20, 0));

        // Held req_valid: exactly two accepts and two pulses.
        a0 = n_acc;
        p0 = n_pulse;
        next_exp   = mk_exp(1, vecs[8].em, vecs[8].ei, vecs[8].ev, vecs[8].ep);
        req_wallet = 2'd1;
        req_valid  = 1'b1;
        for (int g = 0; g < 1000 && n_acc < a0 + 2; g++) tick();
        req_valid = 1'b0;
        wait_drain();
        check("hold_accepts", n_acc - a0, 2);
        check("hold_pulses", n_pulse - p0, 2);

        // Reset in the middle of a divide: no pulse afterwards.
        next_exp   = mk_exp(1, vecs[8].em, vecs[8].ei, vecs[8].ev, vecs[8].ep);
        req_wallet = 2'd1;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (60) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("abort_rst_ready", req_ready, 1'b1);
        check("abort_rst_valid", score_valid, 1'b0);
        sb.delete();
        rst_n = 1'b1;
        p0 = n_pulse;
        repeat (200) tick();
        check("abort_no_pulse", n_pulse - p0, 0);
        check("abort_ready_after", req_ready, 1'b1);
        request(1, mk_exp(1, 0, 0, 0, 0));

        // 65536 txns: counters saturate at 65535 instead of wrapping to 0.
        do_clear(0);
        for (int k = 0; k < 65536; k++) begin
            set_txn(0, 1'b1, 2'b10, 10000, 31'(k));
            tick();
        end
        txn_valid = 1'b0;
        request(0, mk_exp(0, 15, 35, 7, 5));

        check("final_queue_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
